// File: rtl/data_memory_pkg.sv
// Shared definitions for the parametrised data memory: FSM state encoding and
// the byte-lane address split helper.
package data_memory_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // Number of low address bits that select a byte lane inside a word.
    function automatic int LANE_BITS(input int dataWidth);
        return $clog2(dataWidth / 8);
    endfunction

endpackage

// File: rtl/data_memory_lane_sel.sv
// Byte-lane helper: merges one byte into a word for byte writes and extracts a
// zero-extended byte for byte reads. Little-endian, lane 0 = bits [7:0].
module data_memory_lane_sel #(
    parameter int DATA_WIDTH = 16,
    parameter int LB         = 1
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [LB-1:0]         lane,
    input  logic [7:0]            byteIn,
    output logic [DATA_WIDTH-1:0] merged,
    output logic [DATA_WIDTH-1:0] extracted
);

    always_comb begin
        merged    = word;
        extracted = '0;
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            if (lane == LB'(i)) begin
                merged[i*8 +: 8]  = byteIn;
                extracted[7:0]    = word[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/data_memory_pipe.sv
// Byte-addressed data memory with valid/ready requests, configurable read
// latency, self-clearing init sequencer and misalignment/range error flag.
module data_memory_pipe
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  memWrite,
    input  logic                  byte_en,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  err
);

    localparam int LB     = LANE_BITS(DATA_WIDTH);
    localparam int WIDX_W = ADDR_WIDTH - LB;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT_W  = $clog2(READ_LATENCY + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t state, nextState;
    logic [IDX_W-1:0]      clearPtr;
    logic [LAT_W-1:0]      latCnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [WIDX_W-1:0]     inWordIdx;
    logic [LB-1:0]         inLane;
    logic                  inErr;
    logic [IDX_W-1:0]      inIdx;
    logic                  accept;

    logic [IDX_W-1:0]      idxReg;
    logic [LB-1:0]         laneReg;
    logic                  writeReg, byteReg, errReg;

    logic [IDX_W-1:0]      curIdx;
    logic [LB-1:0]         curLane;
    logic                  curWrite, curByte, curErr;
    logic [DATA_WIDTH-1:0] rawWord, mergedWord, extractedWord, writeWord, respData;
    logic                  memWe;
    logic [IDX_W-1:0]      memAddr;
    logic [DATA_WIDTH-1:0] memData;
    logic                  enterResp;

    // Request decode; upper address bits take part in the range check so they never alias.
    assign inWordIdx = address[ADDR_WIDTH-1:LB];
    assign inLane    = address[LB-1:0];
    assign inErr     = ({1'b0, inWordIdx} >= (WIDX_W + 1)'(DEPTH)) ||
                       (!byte_en && (inLane != '0));
    assign inIdx     = inErr ? '0 : inWordIdx[IDX_W-1:0];
    assign accept    = (state == IDLE) && req_valid;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (accept) begin
            idxReg   <= inIdx;
            laneReg  <= inLane;
            writeReg <= memWrite;
            byteReg  <= byte_en;
            errReg   <= inErr;
        end
    end

    // In IDLE the live request is used so a single-cycle latency can respond on the accept edge.
    assign curIdx   = (state == IDLE) ? inIdx    : idxReg;
    assign curLane  = (state == IDLE) ? inLane   : laneReg;
    assign curWrite = (state == IDLE) ? memWrite : writeReg;
    assign curByte  = (state == IDLE) ? byte_en  : byteReg;
    assign curErr   = (state == IDLE) ? inErr    : errReg;

    assign rawWord = mem[curIdx];

    data_memory_lane_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .LB         (LB)
    ) uLaneSel (
        .word      (rawWord),
        .lane      (curLane),
        .byteIn    (writeData[7:0]),
        .merged    (mergedWord),
        .extracted (extractedWord)
    );

    assign writeWord = curByte ? mergedWord : writeData;

    always_comb begin
        respData = '0;
        if (!curErr) begin
            if (curWrite) begin
                respData = (state == IDLE) ? writeWord : rawWord;
            end else begin
                respData = curByte ? extractedWord : rawWord;
            end
        end
    end

    assign memWe   = (state == INIT) || (accept && memWrite && !inErr);
    assign memAddr = (state == INIT) ? clearPtr : inIdx;
    assign memData = (state == INIT) ? '0 : writeWord;

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memAddr] <= memData;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            INIT: if (clearPtr == LAST_IDX) nextState = IDLE;
            IDLE: if (req_valid) nextState = (READ_LATENCY == 1) ? RESP : WAIT;
            WAIT: if (latCnt == LAT_W'(1)) nextState = RESP;
            RESP: nextState = IDLE;
            default: nextState = INIT;
        endcase
    end

    assign enterResp = (nextState == RESP) && (state != RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= INIT;
            clearPtr <= '0;
            latCnt   <= '0;
            readData <= '0;
            err      <= 1'b0;
        end else begin
            state <= nextState;
            if (state == INIT) begin
                clearPtr <= (clearPtr == LAST_IDX) ? '0 : clearPtr + 1'b1;
            end
            if (accept && (READ_LATENCY > 1)) begin
                latCnt <= LAT_W'(READ_LATENCY - 1);
            end else if (state == WAIT) begin
                latCnt <= latCnt - 1'b1;
            end
            if (enterResp) begin
                readData <= respData;
                err      <= curErr;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_pipe.sv
// Directed bench for data_memory_pipe: instance 0 uses READ_LATENCY=1,
// instance 1 uses READ_LATENCY=3; both use the default geometry.
module tb_data_memory_pipe;

    logic        clk = 1'b0;
    logic        rst        [2];
    logic        reqValid   [2];
    logic        reqReady   [2];
    logic        memWrite   [2];
    logic        byteEn     [2];
    logic [15:0] address    [2];
    logic [15:0] writeData  [2];
    logic        respValid  [2];
    logic [15:0] readData   [2];
    logic        err        [2];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    data_memory_pipe #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(256), .READ_LATENCY(1)) dut0 (
        .clk(clk), .reset(rst[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
        .memWrite(memWrite[0]), .byte_en(byteEn[0]), .address(address[0]),
        .writeData(writeData[0]), .resp_valid(respValid[0]), .readData(readData[0]),
        .err(err[0]));

    data_memory_pipe #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(256), .READ_LATENCY(3)) dut1 (
        .clk(clk), .reset(rst[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
        .memWrite(memWrite[1]), .byte_en(byteEn[1]), .address(address[1]),
        .writeData(writeData[1]), .resp_valid(respValid[1]), .readData(readData[1]),
        .err(err[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Counts rising edges after reset release until req_ready rises.
    task automatic waitInit(input int d, output int cycles);
        cycles = 0;
        while (!reqReady[d] && cycles < 400) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // Issues one request, waits for acceptance and the response strobe.
    task automatic doReq(input int d, input logic wr, input logic be, input logic [15:0] addr,
                         input logic [15:0] wd, input string tag,
                         output logic [15:0] rd, output logic e, output int lat);
        bit acc = 0;
        bit found = 0;
        @(negedge clk);
        reqValid[d]  = 1'b1;
        memWrite[d]  = wr;
        byteEn[d]    = be;
        address[d]   = addr;
        writeData[d] = wd;
        for (int i = 0; i < 600 && !acc; i++) begin
            if (i > 0) @(negedge clk);
            if (reqReady[d]) acc = 1;
            @(posedge clk);
        end
        lat = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (i == 0) reqValid[d] = 1'b0;
            lat++;
            if (respValid[d]) found = 1;
        end
        rd = readData[d];
        e  = err[d];
        chk({tag, "_resp_seen"}, {31'd0, found}, 32'd1);
        @(negedge clk);
        chk({tag, "_strobe_width"}, {31'd0, respValid[d]}, 32'd0);
    endtask

    logic [15:0] rd;
    logic        e;
    int          lat;
    int          cyc;
    bit          sawResp;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; reqValid[d] = 1'b0; memWrite[d] = 1'b0;
            byteEn[d] = 1'b0; address[d] = '0; writeData[d] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, reqReady[0]}, 32'd0);
        chk("rst_resp_valid", {31'd0, respValid[0]}, 32'd0);
        chk("rst_read_data", {16'd0, readData[0]}, 32'd0);
        chk("rst_err", {31'd0, err[0]}, 32'd0);
        rst[0] = 1'b1;
        rst[1] = 1'b1;

        // 1: init length and cleared contents
        waitInit(0, cyc);
        chk("init_cycles", cyc, 256);
        chk("init_ready_l3", {31'd0, reqReady[1]}, 32'd1);
        doReq(0, 1'b0, 1'b0, 16'h0004, 16'h0000, "rd4_init", rd, e, lat);
        chk("rd4_init_data", {16'd0, rd}, 32'h0000);
        chk("rd4_init_err", {31'd0, e}, 32'd0);

        // 2: word write/read, latency 1 and 3
        doReq(0, 1'b1, 1'b0, 16'h0002, 16'habcd, "wr2", rd, e, lat);
        chk("wr2_data", {16'd0, rd}, 32'habcd);
        chk("wr2_lat", lat, 1);
        doReq(0, 1'b0, 1'b0, 16'h0002, 16'h0000, "rd2", rd, e, lat);
        chk("rd2_data", {16'd0, rd}, 32'habcd);
        chk("rd2_lat", lat, 1);
        doReq(1, 1'b1, 1'b0, 16'h0002, 16'habcd, "l3_wr2", rd, e, lat);
        chk("l3_wr2_data", {16'd0, rd}, 32'habcd);
        chk("l3_wr2_lat", lat, 3);
        doReq(1, 1'b0, 1'b0, 16'h0002, 16'h0000, "l3_rd2", rd, e, lat);
        chk("l3_rd2_data", {16'd0, rd}, 32'habcd);
        chk("l3_rd2_lat", lat, 3);

        // 3: byte write into lane 1, byte reads of both lanes
        doReq(0, 1'b1, 1'b1, 16'h0003, 16'h1234, "bwr3", rd, e, lat);
        chk("bwr3_data", {16'd0, rd}, 32'h34cd);
        chk("bwr3_err", {31'd0, e}, 32'd0);
        doReq(0, 1'b0, 1'b0, 16'h0002, 16'h0000, "rd2_merged", rd, e, lat);
        chk("rd2_merged_data", {16'd0, rd}, 32'h34cd);
        doReq(0, 1'b0, 1'b1, 16'h0002, 16'h0000, "brd2", rd, e, lat);
        chk("brd2_data", {16'd0, rd}, 32'h00cd);
        doReq(0, 1'b0, 1'b1, 16'h0003, 16'h0000, "brd3", rd, e, lat);
        chk("brd3_data", {16'd0, rd}, 32'h0034);

        // 4: misaligned word write is rejected and modifies nothing
        doReq(0, 1'b1, 1'b0, 16'h0005, 16'hffff, "mis5", rd, e, lat);
        chk("mis5_err", {31'd0, e}, 32'd1);
        chk("mis5_data", {16'd0, rd}, 32'h0000);
        doReq(0, 1'b0, 1'b0, 16'h0004, 16'h0000, "rd4_after", rd, e, lat);
        chk("rd4_after_data", {16'd0, rd}, 32'h0000);
        chk("rd4_after_err", {31'd0, e}, 32'd0);

        // 5: range check including upper address bits
        doReq(0, 1'b0, 1'b0, 16'h0200, 16'h0000, "oor200", rd, e, lat);
        chk("oor200_err", {31'd0, e}, 32'd1);
        chk("oor200_data", {16'd0, rd}, 32'h0000);
        repeat (3) @(negedge clk);
        chk("hold_err", {31'd0, err[0]}, 32'd1);
        chk("hold_resp_valid", {31'd0, respValid[0]}, 32'd0);
        doReq(0, 1'b0, 1'b1, 16'h01ff, 16'h0000, "brd1ff", rd, e, lat);
        chk("brd1ff_err", {31'd0, e}, 32'd0);
        chk("brd1ff_data", {16'd0, rd}, 32'h0000);
        doReq(0, 1'b0, 1'b0, 16'h8004, 16'h0000, "alias8004", rd, e, lat);
        chk("alias8004_err", {31'd0, e}, 32'd1);

        // 6: reset during WAIT suppresses the response and re-clears memory
        @(negedge clk);
        reqValid[1] = 1'b1; memWrite[1] = 1'b0; byteEn[1] = 1'b0; address[1] = 16'h0002;
        chk("l3_pre_ready", {31'd0, reqReady[1]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        reqValid[1] = 1'b0;
        rst[1] = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, reqReady[1]}, 32'd0);
        sawResp = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (respValid[1]) sawResp = 1;
        end
        rst[1] = 1'b1;
        waitInit(1, cyc);
        chk("midrst_no_resp", {31'd0, sawResp}, 32'd0);
        chk("reinit_cycles", cyc, 256);
        doReq(1, 1'b0, 1'b0, 16'h0002, 16'h0000, "l3_rd2_cleared", rd, e, lat);
        chk("l3_rd2_cleared_data", {16'd0, rd}, 32'h0000);
        chk("l3_rd2_cleared_err", {31'd0, e}, 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
